// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE controller micro-loop sequencer.
// Contents: default sizing constants, the microcode word layout, op encodings
// and the sequencer FSM state type.
package hwpe_ctrl_package;

   localparam int unsigned UCODE_LENGTH    = 16;
   localparam int unsigned UCODE_NB_LOOPS  = 6;
   localparam int unsigned UCODE_NB_RO_REG = 28;
   localparam int unsigned UCODE_NB_REG    = 4;
   localparam int unsigned UCODE_REG_WIDTH = 32;
   localparam int unsigned UCODE_CNT_WIDTH = 16;

   // One index space covers both writable and read-only sources, so the
   // a and b fields share its width. An a value past the writable range is
   // a legal encoding and simply writes nothing.
   localparam int unsigned UCODE_SRC_W = $clog2(UCODE_NB_RO_REG + UCODE_NB_REG);

   localparam logic ULOOP_OP_MOV = 1'b0;
   localparam logic ULOOP_OP_ADD = 1'b1;

   typedef struct packed {
      logic                   op_sel;
      logic [UCODE_SRC_W-1:0] a;
      logic [UCODE_SRC_W-1:0] b;
   } uloop_code_t;

   typedef enum logic [1:0] {
      ULOOP_IDLE  = 2'd0,
      ULOOP_VALID = 2'd1,
      ULOOP_EXEC  = 2'd2,
      ULOOP_DONE  = 2'd3
   } uloop_state_e;

endpackage

// File: rtl/hwpe_ctrl_uloop_exec.sv
// Offset register file plus MOV/ADD datapath for the micro-loop sequencer.
// Latency: one instruction per enabled cycle, and the result is visible next cycle.
// Backpressure: none. The caller withholds i_en while it is stalled.
// Ports: i_clk/i_rst_n clock and async reset, i_clear sync zeroing,
//        i_en execute i_code this cycle, i_ro read-only sources, o_regs file.
module hwpe_ctrl_uloop_exec
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned NB_RO_REG = UCODE_NB_RO_REG,
   parameter int unsigned NB_REG    = UCODE_NB_REG,
   parameter int unsigned REG_WIDTH = UCODE_REG_WIDTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_clear,
   input  logic                          i_en,
   input  uloop_code_t                   i_code,
   input  logic [NB_RO_REG*REG_WIDTH-1:0] i_ro,
   output logic [NB_REG*REG_WIDTH-1:0]    o_regs
);

   logic [REG_WIDTH-1:0] r_regs [NB_REG];
   logic [REG_WIDTH-1:0] w_src;

   // The source space is the writable regs first, then the read-only inputs.
   // An index past both ranges reads zero.
   always_comb begin
      w_src = '0;
      for (int i = 0; i < NB_REG; i++) begin
         if (int'(i_code.b) == i) w_src = r_regs[i];
      end
      for (int i = 0; i < NB_RO_REG; i++) begin
         if (int'(i_code.b) == NB_REG + i) w_src = i_ro[i*REG_WIDTH +: REG_WIDTH];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NB_REG; i++) r_regs[i] <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < NB_REG; i++) r_regs[i] <= '0;
      end else if (i_en) begin
         // Only a destination inside the file matches. Any other a drops the write.
         for (int i = 0; i < NB_REG; i++) begin
            if (int'(i_code.a) == i) begin
               r_regs[i] <= (i_code.op_sel == ULOOP_OP_ADD) ? r_regs[i] + w_src : w_src;
            end
         end
      end
   end

   for (genvar g = 0; g < NB_REG; g++) begin : g_regs_out
      assign o_regs[g*REG_WIDTH +: REG_WIDTH] = r_regs[g];
   end

endmodule

// File: rtl/hwpe_ctrl_uloop.sv
// Nested-loop microcode sequencer. It emits (idx, offs) tuples for streamer control.
// Latency: the first tuple comes 1 cycle after start. A tuple after a level-l step waits for nb_ops[l] EXEC cycles.
// Backpressure: valid/ready. A stalled tuple holds idx/offs and runs no ops.
// Ports: clk_i/rst_ni clock and async reset, clear_i sync clear, start_i/busy_o/done_o control,
//        range/loop_addr/loop_nb_ops/code/registers_read config, valid_o/ready_i/idx_o/offs_o/accum_o tuple.
module hwpe_ctrl_uloop
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned LENGTH    = UCODE_LENGTH,
   parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
   parameter int unsigned NB_RO_REG = UCODE_NB_RO_REG,
   parameter int unsigned NB_REG    = UCODE_NB_REG,
   parameter int unsigned REG_WIDTH = UCODE_REG_WIDTH,
   parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  test_mode_i,
   input  logic                                  clear_i,
   input  logic                                  start_i,
   input  logic [$clog2(NB_LOOPS)-1:0]           accum_loop_i,
   input  logic [NB_LOOPS*CNT_WIDTH-1:0]         range_i,
   input  logic [NB_LOOPS*$clog2(LENGTH)-1:0]    loop_addr_i,
   input  logic [NB_LOOPS*$clog2(LENGTH+1)-1:0]  loop_nb_ops_i,
   input  uloop_code_t [LENGTH-1:0]              code_i,
   input  logic [NB_RO_REG*REG_WIDTH-1:0]        registers_read_i,
   output logic                                  valid_o,
   input  logic                                  ready_i,
   output logic [NB_LOOPS*CNT_WIDTH-1:0]         idx_o,
   output logic [NB_REG*REG_WIDTH-1:0]           offs_o,
   output logic                                  accum_o,
   output logic                                  busy_o,
   output logic                                  done_o
);

   localparam int unsigned LVL_W  = $clog2(NB_LOOPS);
   localparam int unsigned ADDR_W = $clog2(LENGTH);
   localparam int unsigned OPS_W  = $clog2(LENGTH+1);
   localparam int unsigned SUM_W  = ADDR_W + 2;

   uloop_state_e         r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0] r_idx [NB_LOOPS];
   logic [OPS_W-1:0]     r_cnt;
   logic [LVL_W-1:0]     r_level;

   logic [CNT_WIDTH-1:0] w_last   [NB_LOOPS];
   logic [ADDR_W-1:0]    w_addr   [NB_LOOPS];
   logic [OPS_W-1:0]     w_nb_ops [NB_LOOPS];
   logic                 w_found;
   logic [LVL_W-1:0]     w_level;
   logic                 w_accum_ok;
   logic                 w_exec_en;
   logic                 w_regs_clr;
   logic                 w_hs;
   logic [SUM_W-1:0]     w_pc_sum;
   logic [ADDR_W-1:0]    w_pc;
   logic                 w_unused_test_mode;

   assign w_unused_test_mode = test_mode_i;

   // Split the flat config buses into arrays. A range of 0 counts as 1, so its last index is 0.
   for (genvar g = 0; g < NB_LOOPS; g++) begin : g_cfg
      assign w_last[g]   = (range_i[g*CNT_WIDTH +: CNT_WIDTH] == '0) ? '0
                         : range_i[g*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
      assign w_addr[g]   = loop_addr_i[g*ADDR_W +: ADDR_W];
      assign w_nb_ops[g] = loop_nb_ops_i[g*OPS_W +: OPS_W];
      assign idx_o[g*CNT_WIDTH +: CNT_WIDTH] = r_idx[g];
   end

   // Level finder: the innermost loop that still has iterations left.
   always_comb begin
      w_found = 1'b0;
      w_level = '0;
      for (int l = NB_LOOPS-1; l >= 0; l--) begin
         if (r_idx[l] < w_last[l]) begin
            w_found = 1'b1;
            w_level = LVL_W'(l);
         end
      end
   end

   // A tuple closes an accumulation when every loop below accum_loop_i is at its last index.
   always_comb begin
      w_accum_ok = 1'b1;
      for (int j = 0; j < NB_LOOPS; j++) begin
         if (j < int'(accum_loop_i) && r_idx[j] != w_last[j]) w_accum_ok = 1'b0;
      end
   end

   // The instruction address wraps within the microcode memory.
   // cnt < nb_ops <= LENGTH, so the sum is below 2*LENGTH and one subtraction suffices.
   assign w_pc_sum = SUM_W'(w_addr[r_level]) + SUM_W'(r_cnt);
   assign w_pc     = (w_pc_sum >= SUM_W'(LENGTH)) ? ADDR_W'(w_pc_sum - SUM_W'(LENGTH))
                                                  : ADDR_W'(w_pc_sum);

   assign w_hs    = (r_state == ULOOP_VALID) && ready_i;
   assign busy_o  = (r_state != ULOOP_IDLE);
   assign accum_o = valid_o && w_accum_ok;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ULOOP_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_exec_en   = 1'b0;
      w_regs_clr  = 1'b0;
      valid_o     = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         ULOOP_IDLE: begin
            if (start_i) begin
               w_state_nxt = ULOOP_VALID;
               w_regs_clr  = 1'b1;
            end
         end
         ULOOP_VALID: begin
            valid_o = 1'b1;
            if (ready_i) begin
               if (!w_found)                    w_state_nxt = ULOOP_DONE;
               else if (w_nb_ops[w_level] != '0) w_state_nxt = ULOOP_EXEC;
            end
         end
         ULOOP_EXEC: begin
            w_exec_en = 1'b1;
            if (r_cnt + OPS_W'(1) == w_nb_ops[r_level]) w_state_nxt = ULOOP_VALID;
         end
         ULOOP_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = ULOOP_IDLE;
         end
         default: w_state_nxt = ULOOP_IDLE;
      endcase
      if (clear_i) begin
         w_state_nxt = ULOOP_IDLE;
         w_regs_clr  = 1'b1;
         w_exec_en   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int j = 0; j < NB_LOOPS; j++) r_idx[j] <= '0;
         r_cnt   <= '0;
         r_level <= '0;
      end else if (clear_i) begin
         for (int j = 0; j < NB_LOOPS; j++) r_idx[j] <= '0;
         r_cnt   <= '0;
         r_level <= '0;
      end else begin
         if (r_state == ULOOP_IDLE && start_i) begin
            for (int j = 0; j < NB_LOOPS; j++) r_idx[j] <= '0;
            r_cnt <= '0;
         end
         // The step is latched at the handshake, so EXEC and the next tuple see the new indices.
         if (w_hs && w_found) begin
            for (int j = 0; j < NB_LOOPS; j++) begin
               if (j < int'(w_level))       r_idx[j] <= '0;
               else if (j == int'(w_level)) r_idx[j] <= r_idx[j] + CNT_WIDTH'(1);
            end
            r_level <= w_level;
            r_cnt   <= '0;
         end
         if (r_state == ULOOP_EXEC) r_cnt <= r_cnt + OPS_W'(1);
      end
   end

   hwpe_ctrl_uloop_exec #(
      .NB_RO_REG (NB_RO_REG),
      .NB_REG    (NB_REG),
      .REG_WIDTH (REG_WIDTH)
   ) i_exec (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clear (w_regs_clr),
      .i_en    (w_exec_en),
      .i_code  (code_i[w_pc]),
      .i_ro    (registers_read_i),
      .o_regs  (offs_o)
   );

endmodule

// File: tb/tb_hwpe_ctrl_uloop.sv
// Bench for hwpe_ctrl_uloop. Directed runs push their expected outputs into a
// queue, and a negedge monitor compares every valid tuple and done pulse against it.
module tb_hwpe_ctrl_uloop;
   import hwpe_ctrl_package::*;

   localparam int LEN = 16, NL = 2, NRO = 28, NR = 4, RW = 32, CW = 16;

   logic clk_i = 1'b0, rst_ni = 1'b0, test_mode_i = 1'b0, clear_i = 1'b0;
   logic start_i = 1'b0, ready_i = 1'b0;
   logic [0:0]           accum_loop_i = '0;
   logic [NL*CW-1:0]     range_i = '0;
   logic [NL*4-1:0]      loop_addr_i = '0;
   logic [NL*5-1:0]      loop_nb_ops_i = '0;
   uloop_code_t [LEN-1:0] code_i;
   logic [NRO*RW-1:0]    registers_read_i = '0;
   logic                 valid_o, accum_o, busy_o, done_o;
   logic [NL*CW-1:0]     idx_o;
   logic [NR*RW-1:0]     offs_o;

   typedef struct {
      bit           is_done;
      logic [31:0]  idx;
      logic [127:0] offs;
      bit           acc;
      int           lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, last_ev = 0;

   always #5 clk_i = ~clk_i;

   hwpe_ctrl_uloop #(
      .LENGTH(LEN), .NB_LOOPS(NL), .NB_RO_REG(NRO), .NB_REG(NR), .REG_WIDTH(RW), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
      .start_i(start_i), .accum_loop_i(accum_loop_i), .range_i(range_i),
      .loop_addr_i(loop_addr_i), .loop_nb_ops_i(loop_nb_ops_i), .code_i(code_i),
      .registers_read_i(registers_read_i), .valid_o(valid_o), .ready_i(ready_i),
      .idx_o(idx_o), .offs_o(offs_o), .accum_o(accum_o), .busy_o(busy_o), .done_o(done_o)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic uloop_code_t mkop(input logic op, input int a, input int b);
      uloop_code_t c;
      c.op_sel = op;
      c.a      = UCODE_SRC_W'(a);
      c.b      = UCODE_SRC_W'(b);
      return c;
   endfunction

   task automatic cfg(input int r1, input int r0, input int a1, input int a0,
                      input int o1, input int o0, input int acc);
      range_i       = {16'(r1), 16'(r0)};
      loop_addr_i   = {4'(a1), 4'(a0)};
      loop_nb_ops_i = {5'(o1), 5'(o0)};
      accum_loop_i  = 1'(acc);
      code_i        = '0;
   endtask

   task automatic push_t(input int i1, input int i0, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3, input bit acc, input int lat);
      exp_t e;
      e.is_done = 1'b0;
      e.idx     = {16'(i1), 16'(i0)};
      e.offs    = {r3, r2, r1, r0};
      e.acc     = acc;
      e.lat     = lat;
      exp_q.push_back(e);
   endtask

   task automatic push_d(input int lat);
      exp_t e;
      e.is_done = 1'b1;
      e.idx     = '0;
      e.offs    = '0;
      e.acc     = 1'b0;
      e.lat     = lat;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge clk_i); #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      n_vec++;
      if (n >= 200) begin
         n_err++;
         $display("FAIL %s_timeout: %0d outputs still pending, busy_o=%0b, required drained", name, exp_q.size(), busy_o);
      end
      exp_q.delete();
   endtask

   // Basic nest program: loop0 r0+=ro0; loop1 r1+=ro1, r0=ro2.
   task automatic prog_basic(input int acc);
      cfg(2, 3, 4, 0, 2, 1, acc);
      code_i[0] = mkop(ULOOP_OP_ADD, 0, NR + 0);
      code_i[4] = mkop(ULOOP_OP_ADD, 1, NR + 1);
      code_i[5] = mkop(ULOOP_OP_MOV, 0, NR + 2);
   endtask

   task automatic push_basic();
      push_t(0, 0, 0, 0,   0, 0, 1, 1);
      push_t(0, 1, 4, 0,   0, 0, 1, -1);
      push_t(0, 2, 8, 0,   0, 0, 1, -1);
      push_t(1, 0, 0, 100, 0, 0, 1, -1);
      push_t(1, 1, 4, 100, 0, 0, 1, -1);
      push_t(1, 2, 8, 100, 0, 0, 1, -1);
      push_d(1);
   endtask

   // Monitor: compare the queue head whenever the DUT presents a tuple or a done pulse.
   initial begin
      forever begin
         @(negedge clk_i);
         cyc++;
         if (rst_ni) begin
            if (start_i && !busy_o) last_ev = cyc;
            if (valid_o) begin
               if (exp_q.size() == 0 || exp_q[0].is_done) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_valid: idx_o=%h offs_o=%h, required no tuple here", idx_o, offs_o);
               end else begin
                  chk("tuple_idx",   128'(idx_o),   128'(exp_q[0].idx));
                  chk("tuple_offs",  128'(offs_o),  exp_q[0].offs);
                  chk("tuple_accum", 128'(accum_o), 128'(exp_q[0].acc));
                  if (ready_i) begin
                     if (exp_q[0].lat >= 0) chk("tuple_latency", 128'(cyc - last_ev), 128'(exp_q[0].lat));
                     last_ev = cyc;
                     void'(exp_q.pop_front());
                  end
               end
            end
            if (done_o) begin
               if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_done: done_o=1 with %0d outputs pending, required no done", exp_q.size());
               end else begin
                  if (exp_q[0].lat >= 0) chk("done_latency", 128'(cyc - last_ev), 128'(exp_q[0].lat));
                  last_ev = cyc;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int n;
      code_i = '0;
      registers_read_i[0*RW +: RW] = 32'd4;
      registers_read_i[1*RW +: RW] = 32'd100;
      registers_read_i[2*RW +: RW] = 32'd0;
      registers_read_i[3*RW +: RW] = 32'hFFFF_FFFF;
      registers_read_i[4*RW +: RW] = 32'd1;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      chk("reset_valid", 128'(valid_o), 128'(0));
      chk("reset_busy",  128'(busy_o),  128'(0));
      chk("reset_done",  128'(done_o),  128'(0));
      chk("reset_accum", 128'(accum_o), 128'(0));
      chk("reset_idx",   128'(idx_o),   128'(0));
      chk("reset_offs",  128'(offs_o),  128'(0));

      // Basic nest, ready held high.
      prog_basic(0);
      ready_i = 1'b1;
      push_basic();
      pulse_start();
      wait_drain("basic");

      // Backpressure: hold ready low for 5 cycles while tuple (0,1) is presented.
      prog_basic(0);
      push_basic();
      pulse_start();
      n = 0;
      do begin @(negedge clk_i); n++; end while (!(busy_o && !valid_o) && n < 20);
      @(posedge clk_i); #1 ready_i = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         chk("bp_valid_held", 128'(valid_o), 128'(1));
      end
      @(posedge clk_i); #1 ready_i = 1'b1;
      wait_drain("backpressure");

      // Zero-op loops: three back-to-back tuples.
      cfg(1, 3, 0, 0, 0, 0, 0);
      push_t(0, 0, 0, 0, 0, 0, 1, 1);
      push_t(0, 1, 0, 0, 0, 0, 1, 1);
      push_t(0, 2, 0, 0, 0, 0, 1, 1);
      push_d(1);
      pulse_start();
      wait_drain("zero_op");

      // Accumulation flag on level 1.
      cfg(2, 2, 0, 0, 0, 0, 1);
      push_t(0, 0, 0, 0, 0, 0, 0, 1);
      push_t(0, 1, 0, 0, 0, 0, 1, 1);
      push_t(1, 0, 0, 0, 0, 0, 0, 1);
      push_t(1, 1, 0, 0, 0, 0, 1, 1);
      push_d(1);
      pulse_start();
      wait_drain("accum");

      // Clear during EXEC, then replay from the beginning.
      prog_basic(0);
      push_t(0, 0, 0, 0, 0, 0, 1, 1);
      pulse_start();
      n = 0;
      do begin @(negedge clk_i); n++; end while (!(busy_o && !valid_o) && n < 20);
      chk("clear_in_exec", 128'(busy_o && !valid_o), 128'(1));
      clear_i = 1'b1;
      @(posedge clk_i); #1 clear_i = 1'b0;
      @(negedge clk_i);
      chk("clear_busy",  128'(busy_o),  128'(0));
      chk("clear_valid", 128'(valid_o), 128'(0));
      chk("clear_done",  128'(done_o),  128'(0));
      chk("clear_accum", 128'(accum_o), 128'(0));
      chk("clear_idx",   128'(idx_o),   128'(0));
      chk("clear_offs",  128'(offs_o),  128'(0));
      chk("clear_pending", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      push_basic();
      pulse_start();
      wait_drain("replay");

      // Wrap: ops at 13..1 wrap the address; r0 = FFFFFFFF + 1 = 0; write to a=4 is dropped.
      cfg(1, 2, 0, 13, 0, 5, 0);
      code_i[13] = mkop(ULOOP_OP_MOV, 0, NR + 3);
      code_i[14] = mkop(ULOOP_OP_ADD, 0, NR + 4);
      code_i[15] = mkop(ULOOP_OP_ADD, 2, NR + 3);
      code_i[0]  = mkop(ULOOP_OP_MOV, 1, 2);
      code_i[1]  = mkop(ULOOP_OP_MOV, 4, NR + 3);
      push_t(0, 0, 0, 0, 0, 0, 1, 1);
      push_t(0, 1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, -1);
      push_d(1);
      pulse_start();
      wait_drain("wrap");

      // Range 0 behaves as range 1: a single tuple, then done.
      cfg(0, 0, 0, 0, 0, 0, 0);
      push_t(0, 0, 0, 0, 0, 0, 1, 1);
      push_d(1);
      pulse_start();
      wait_drain("range0");

      repeat (3) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
